// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-side PC logic.
// Holds FSM encodings, step sizes and default vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_BAD  = 2'b11
    } pc_state_e;

    localparam int INSN_STEP4 = 4;
    localparam int INSN_STEP2 = 2;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the RUN state.
// Priority: trap, mret, aligned branch, misaligned branch, stall, step.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter int              C_EXT    = 0
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            insn_len2_i,
    input  logic            trap_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] next_pc,
    output logic            take_trap,
    output logic            misalign
);

    logic            bad_tgt;
    logic [XLEN-1:0] step;

    // Without compressed insns every target must be word aligned.
    assign bad_tgt = br_target_i[0] | ((C_EXT == 0) & br_target_i[1]);
    assign step = ((C_EXT != 0) && insn_len2_i) ? XLEN'(INSN_STEP2)
                                                : XLEN'(INSN_STEP4);

    always_comb begin
        next_pc   = pc + step;
        take_trap = 1'b0;
        misalign  = 1'b0;
        if (trap_i) begin
            next_pc   = TRAP_VEC;
            take_trap = 1'b1;
        end else if (mret_i) begin
            next_pc = epc;
        end else if (br_taken_i && !bad_tgt) begin
            next_pc = br_target_i;
        end else if (br_taken_i) begin
            next_pc   = TRAP_VEC;
            take_trap = 1'b1;
            misalign  = 1'b1;
        end else if (stall_i) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with boot hold, halt/resume, EPC and
// misaligned-redirect trapping; feeds instruction fetch.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC    = DEF_TRAP_VEC,
    parameter int              BOOT_CYCLES = 2,
    parameter int              C_EXT       = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            insn_len2_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic [1:0]      state_o
);

    pc_state_e       state_q, state_d;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] pc_q, epc_q;
    logic            mis_q, valid_q, valid_d;
    logic [XLEN-1:0] next_pc;
    logic            take_trap, misalign;
    logic            run;

    assign run = (state_q == ST_RUN);

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .C_EXT    (C_EXT)
    ) u_sel (
        .pc          (pc_q),
        .epc         (epc_q),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .insn_len2_i (insn_len2_i),
        .trap_i      (trap_i),
        .mret_i      (mret_i),
        .next_pc     (next_pc),
        .take_trap   (take_trap),
        .misalign    (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: begin
                if (BOOT_CYCLES == 0 || cnt_q == 4'(BOOT_CYCLES - 1))
                    state_d = ST_RUN;
            end
            ST_RUN:  if (halt_i) state_d = ST_HALT;
            ST_HALT: if (resume_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            // Counter restarts if BOOT is re-entered from the unused state.
            cnt_q <= (state_q == ST_BOOT) ? cnt_q + 4'd1 : 4'd0;
            mis_q <= run & misalign;
            if (run) begin
                pc_q <= next_pc;
                if (take_trap)
                    epc_q <= pc_q;
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign epc_o      = epc_q;
    assign misalign_o = mis_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural model, for C_EXT=0 and C_EXT=1 instances.
module tb_pc_unit;

    localparam int BOOT = 2;
    localparam logic [31:0] TVEC = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_i, br_taken_i, insn_len2_i;
    logic        trap_i, mret_i, halt_i, resume_i;
    logic [31:0] br_target_i;

    logic [31:0] d_pc[2], d_epc[2];
    logic        d_valid[2], d_mis[2];
    logic [1:0]  d_st[2];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc[2], m_epc[2];
    bit          m_mis[2], m_valid[2];
    int          m_st[2], m_cnt[2];

    pc_unit #(.BOOT_CYCLES(BOOT), .C_EXT(0)) u_dut0 (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .insn_len2_i(insn_len2_i), .trap_i(trap_i), .mret_i(mret_i),
        .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(d_pc[0]), .pc_valid_o(d_valid[0]), .epc_o(d_epc[0]),
        .misalign_o(d_mis[0]), .state_o(d_st[0])
    );

    pc_unit #(.BOOT_CYCLES(BOOT), .C_EXT(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .insn_len2_i(insn_len2_i), .trap_i(trap_i), .mret_i(mret_i),
        .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(d_pc[1]), .pc_valid_o(d_valid[1]), .epc_o(d_epc[1]),
        .misalign_o(d_mis[1]), .state_o(d_st[1])
    );

    // Model: index k is the instance; k==1 has compressed support.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit mis;
            bit odd;
            mis = 0;
            if (!rst) begin
                m_pc[k] = 0; m_epc[k] = 0;
                m_st[k] = 0; m_cnt[k] = 0;
            end else begin
                case (m_st[k])
                    0: begin
                        m_cnt[k]++;
                        if (m_cnt[k] >= BOOT) m_st[k] = 1;
                    end
                    1: begin
                        odd = br_target_i[0] || (k == 0 && br_target_i[1]);
                        if (trap_i) begin
                            m_epc[k] = m_pc[k]; m_pc[k] = TVEC;
                        end else if (mret_i) begin
                            m_pc[k] = m_epc[k];
                        end else if (br_taken_i && !odd) begin
                            m_pc[k] = br_target_i;
                        end else if (br_taken_i) begin
                            m_epc[k] = m_pc[k]; m_pc[k] = TVEC; mis = 1;
                        end else if (!stall_i) begin
                            m_pc[k] = m_pc[k] + ((k == 1 && insn_len2_i) ? 2 : 4);
                        end
                        if (halt_i) m_st[k] = 2;
                    end
                    default: if (resume_i) m_st[k] = 1;
                endcase
            end
            m_mis[k] = mis;
            m_valid[k] = (m_st[k] == 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        stall_i = 0; br_taken_i = 0; br_target_i = 0; insn_len2_i = 0;
        trap_i = 0; mret_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 0;
        repeat (3) tick();
        checks += 5;
        if (d_pc[0] !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", d_pc[0]); end
        if (d_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", d_valid[0]); end
        if (d_st[0] !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", d_st[0]); end
        if (d_epc[0] !== 32'h0) begin errors++; $display("FAIL rst_epc: got %h want 0", d_epc[0]); end
        if (d_mis[0] !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", d_mis[0]); end
        rst = 1;
        tick();
        checks += 2;
        if (d_valid[0] !== 1'b0) begin errors++; $display("FAIL boot1_valid: got %b want 0", d_valid[0]); end
        if (d_st[0] !== 2'b00) begin errors++; $display("FAIL boot1_state: got %b want 00", d_st[0]); end
        tick();
        checks += 3;
        if (d_valid[0] !== 1'b1) begin errors++; $display("FAIL run_valid: got %b want 1", d_valid[0]); end
        if (d_st[0] !== 2'b01) begin errors++; $display("FAIL run_state: got %b want 01", d_st[0]); end
        if (d_pc[0] !== 32'h0) begin errors++; $display("FAIL run_pc0: got %h want 0", d_pc[0]); end
        tick();
        checks++;
        if (d_pc[0] !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want 4", d_pc[0]); end
        tick();
        checks++;
        if (d_pc[0] !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h want 8", d_pc[0]); end
    endtask

    task automatic test_stall_branch();
        stall_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (d_pc[0] !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h want 8", d_pc[0]); end
        end
        br_taken_i = 1; br_target_i = 32'h40;
        tick();
        checks++;
        if (d_pc[0] !== 32'h40) begin errors++; $display("FAIL br_over_stall: got %h want 40", d_pc[0]); end
        idle();
    endtask

    task automatic test_misalign();
        br_taken_i = 1; br_target_i = 32'h10;
        tick();
        br_target_i = 32'h42;
        tick();
        checks += 5;
        if (d_pc[0] !== TVEC) begin errors++; $display("FAIL mis_pc: got %h want %h", d_pc[0], TVEC); end
        if (d_epc[0] !== 32'h10) begin errors++; $display("FAIL mis_epc: got %h want 10", d_epc[0]); end
        if (d_mis[0] !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", d_mis[0]); end
        if (d_pc[1] !== 32'h42) begin errors++; $display("FAIL cext_br: got %h want 42", d_pc[1]); end
        if (d_mis[1] !== 1'b0) begin errors++; $display("FAIL cext_mis: got %b want 0", d_mis[1]); end
        idle();
        tick();
        checks += 2;
        if (d_mis[0] !== 1'b0) begin errors++; $display("FAIL mis_once: got %b want 0", d_mis[0]); end
        if (d_pc[0] !== 32'h104) begin errors++; $display("FAIL mis_after: got %h want 104", d_pc[0]); end
    endtask

    task automatic test_trap_mret();
        br_taken_i = 1; br_target_i = 32'h20;
        tick();
        idle(); trap_i = 1;
        tick();
        checks += 2;
        if (d_pc[0] !== TVEC) begin errors++; $display("FAIL trap_pc: got %h want %h", d_pc[0], TVEC); end
        if (d_epc[0] !== 32'h20) begin errors++; $display("FAIL trap_epc: got %h want 20", d_epc[0]); end
        idle();
        tick();
        mret_i = 1;
        tick();
        checks++;
        if (d_pc[0] !== 32'h20) begin errors++; $display("FAIL mret_pc: got %h want 20", d_pc[0]); end
        idle();
        tick();
        trap_i = 1; mret_i = 1;
        tick();
        checks += 2;
        if (d_pc[0] !== TVEC) begin errors++; $display("FAIL trapmret_pc: got %h want %h", d_pc[0], TVEC); end
        if (d_epc[0] !== 32'h24) begin errors++; $display("FAIL trapmret_epc: got %h want 24", d_epc[0]); end
        idle();
    endtask

    task automatic test_halt();
        br_taken_i = 1; br_target_i = 32'h30;
        tick();
        idle(); halt_i = 1;
        tick();
        checks += 3;
        if (d_pc[0] !== 32'h34) begin errors++; $display("FAIL halt_pc: got %h want 34", d_pc[0]); end
        if (d_st[0] !== 2'b10) begin errors++; $display("FAIL halt_state: got %b want 10", d_st[0]); end
        if (d_valid[0] !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b want 0", d_valid[0]); end
        idle(); br_taken_i = 1; br_target_i = 32'h80; trap_i = 1;
        tick();
        checks++;
        if (d_pc[0] !== 32'h34) begin errors++; $display("FAIL halt_ignore: got %h want 34", d_pc[0]); end
        idle(); halt_i = 1; resume_i = 1;
        tick();
        checks += 3;
        if (d_pc[0] !== 32'h34) begin errors++; $display("FAIL resume_pc: got %h want 34", d_pc[0]); end
        if (d_st[0] !== 2'b01) begin errors++; $display("FAIL resume_state: got %b want 01", d_st[0]); end
        if (d_valid[0] !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b want 1", d_valid[0]); end
        idle();
        tick();
        checks++;
        if (d_pc[0] !== 32'h38) begin errors++; $display("FAIL resume_step: got %h want 38", d_pc[0]); end
    endtask

    task automatic test_wrap_reset();
        br_taken_i = 1; br_target_i = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        checks++;
        if (d_pc[0] !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", d_pc[0]); end
        br_taken_i = 1; br_target_i = 32'h42; halt_i = 1;
        tick();
        checks += 3;
        if (d_pc[0] !== TVEC) begin errors++; $display("FAIL halt_mis_pc: got %h want %h", d_pc[0], TVEC); end
        if (d_st[0] !== 2'b10) begin errors++; $display("FAIL halt_mis_state: got %b want 10", d_st[0]); end
        if (d_mis[0] !== 1'b1) begin errors++; $display("FAIL halt_mis_pulse: got %b want 1", d_mis[0]); end
        idle(); rst = 0;
        tick();
        checks += 5;
        if (d_pc[0] !== 32'h0) begin errors++; $display("FAIL mid_rst_pc: got %h want 0", d_pc[0]); end
        if (d_st[0] !== 2'b00) begin errors++; $display("FAIL mid_rst_state: got %b want 00", d_st[0]); end
        if (d_mis[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_mis: got %b want 0", d_mis[0]); end
        if (d_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", d_valid[0]); end
        if (d_epc[0] !== 32'h0) begin errors++; $display("FAIL mid_rst_epc: got %h want 0", d_epc[0]); end
        rst = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 79) != 0);
            trap_i      = ($urandom_range(0, 15) == 0);
            mret_i      = ($urandom_range(0, 11) == 0);
            br_taken_i  = ($urandom_range(0, 4) == 0);
            stall_i     = ($urandom_range(0, 3) == 0);
            halt_i      = ($urandom_range(0, 19) == 0);
            resume_i    = ($urandom_range(0, 3) == 0);
            insn_len2_i = $urandom_range(0, 1) == 1;
            br_target_i = $urandom;
            if ($urandom_range(0, 7) == 0) br_target_i[31:4] = '1;
            if ($urandom_range(0, 1) == 0) br_target_i[1:0] = 2'b00;
            tick();
            for (int k = 0; k < 2; k++) begin
                checks += 5;
                if (d_pc[k] !== m_pc[k]) begin
                    errors++; $display("FAIL rnd_pc[%0d] cyc %0d: got %h want %h", k, i, d_pc[k], m_pc[k]);
                end
                if (d_epc[k] !== m_epc[k]) begin
                    errors++; $display("FAIL rnd_epc[%0d] cyc %0d: got %h want %h", k, i, d_epc[k], m_epc[k]);
                end
                if (d_valid[k] !== m_valid[k]) begin
                    errors++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, i, d_valid[k], m_valid[k]);
                end
                if (d_mis[k] !== m_mis[k]) begin
                    errors++; $display("FAIL rnd_mis[%0d] cyc %0d: got %b want %b", k, i, d_mis[k], m_mis[k]);
                end
                if (d_st[k] !== 2'(m_st[k])) begin
                    errors++; $display("FAIL rnd_state[%0d] cyc %0d: got %b want %0d", k, i, d_st[k], m_st[k]);
                end
            end
        end
        idle(); rst = 1;
    endtask

    initial begin
        idle(); rst = 0;
        test_reset();
        test_stall_branch();
        test_misalign();
        test_trap_mret();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
